// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmitter state encoding and the
// bit-period helper used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Clock cycles per bit, truncated; both line ends must use this same rounding.
  function automatic int unsigned bps_cnt(input int unsigned clk_freq,
                                          input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period counter; flags the last cycle of every bit period.
// Wraps on its own at bit_end, so it restarts at zero whenever the caller
// changes bit or state on that edge.
module uart_baud_cnt #(
  parameter int unsigned BPS_CNT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int unsigned CntW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(BPS_CNT - 1);

  logic [CntW-1:0] cnt_q;

  // Count 0..BPS_CNT-1, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign bit_end = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2, LSB first, idle high. A one-byte holding
// register lets the producer queue the next byte during the current frame,
// so consecutive frames go out with no idle gap.
module uart_tx import uart_pkg::*; #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_if.slave        bus,
  output logic            rs232_tx,
  output logic            busy
);

  localparam int unsigned BPS_CNT = bps_cnt(CLK_FREQ, BAUD);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic StopLast = (STOP_BITS == 2);

  tx_state_e         state_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_idx_q;
  logic              stop_idx_q;
  logic              tx_q;
  logic              busy_q;

  logic bit_end;
  logic cnt_clr;
  logic accept;

  assign bus.tx_ready = !hold_full_q;
  assign accept       = bus.tx_valid && !hold_full_q;
  // Every non-idle transition lands on bit_end, where the counter wraps anyway,
  // so holding it clear in idle is enough to restart it on each state change.
  assign cnt_clr      = (state_q == StIdle);

  uart_baud_cnt #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .bit_end (bit_end)
  );

  // Holding register, framing FSM and registered line/busy outputs.
  // Accept needs hold_full_q=0 and load needs hold_full_q=1, so the two
  // hold_full_q updates below never collide on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= bus.tx_data;
        hold_full_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (hold_full_q) begin
            shift_q     <= hold_q;
            hold_full_q <= 1'b0;
            state_q     <= StStart;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
          end
        end

        StData: begin
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q    <= StStop;
              stop_idx_q <= 1'b0;
              tx_q       <= 1'b1;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end

        StStop: begin
          if (bit_end) begin
            if (stop_idx_q == StopLast) begin
              if (hold_full_q) begin
                // Chain straight into the next frame without an idle cycle.
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                state_q     <= StStart;
                tx_q        <= 1'b0;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= StIdle;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rs232_tx = tx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at CLK_FREQ=1000, BAUD=100 (10 cycles per bit), with a
// one-stop-bit instance and a two-stop-bit instance side by side.
module tb_uart_tx;

  localparam int Bps = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx1, tx2, busy1, busy2;

  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .STOP_BITS (1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if1),
    .rs232_tx (tx1),
    .busy     (busy1)
  );

  uart_tx #(
    .CLK_FREQ  (1000),
    .BAUD      (100),
    .STOP_BITS (2)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .bus      (if2),
    .rs232_tx (tx2),
    .busy     (busy2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int edge_n = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame model: each instance is either idle (pos<0) or at cycle pos of a
  // frame of (1+8+stop)*Bps cycles; one pending byte may wait behind it.
  int         m_pos   [2] = '{-1, -1};
  bit         m_pend  [2] = '{1'b0, 1'b0};
  logic [7:0] m_cur   [2];
  logic [7:0] m_pbyte [2];

  function automatic int flen(input int k);
    return (1 + 8 + (k + 1)) * Bps;
  endfunction

  function automatic logic m_line(input int k);
    int b;
    if (m_pos[k] < 0) return 1'b1;
    b = m_pos[k] / Bps;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[k][b-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      bit         v;
      bit         acc;
      bit         was_idle;
      logic [7:0] d;
      v = (k == 0) ? if1.tx_valid : if2.tx_valid;
      d = (k == 0) ? if1.tx_data : if2.tx_data;
      if (rst) begin
        m_pos[k]  = -1;
        m_pend[k] = 1'b0;
      end else begin
        acc      = v && !m_pend[k];
        was_idle = (m_pos[k] < 0);
        if (!was_idle) m_pos[k]++;
        if (was_idle || m_pos[k] == flen(k)) begin
          if (m_pend[k]) begin
            m_pos[k]  = 0;
            m_cur[k]  = m_pbyte[k];
            m_pend[k] = 1'b0;
          end else begin
            m_pos[k] = -1;
          end
        end
        if (acc) begin
          m_pend[k]  = 1'b1;
          m_pbyte[k] = d;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the frame model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("line1",  int'(tx1),           int'(m_line(0)));
      chk("busy1",  int'(busy1),         int'(m_pos[0] >= 0));
      chk("ready1", int'(if1.tx_ready),  int'(!m_pend[0]));
      chk("line2",  int'(tx2),           int'(m_line(1)));
      chk("busy2",  int'(busy2),         int'(m_pos[1] >= 0));
      chk("ready2", int'(if2.tx_ready),  int'(!m_pend[1]));
    end
  end

  // Line receiver on instance 1: mid-bit sampling, one stop bit.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         frame_err = 0;
  int         cyc = 0;
  bit         rx_on = 1'b0;
  int         rx_t = 0;
  logic [7:0] rx_byte = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (chk_en && tx1 === 1'b0) begin
        rx_on = 1'b1;
        rx_t  = 0;
        rx_start.push_back(cyc);
      end
    end else begin
      rx_t++;
      if (rx_t % Bps == Bps / 2 && rx_t / Bps >= 1 && rx_t / Bps <= 8)
        rx_byte[rx_t/Bps-1] = tx1;
      if (rx_t == 9 * Bps + Bps / 2) begin
        if (tx1 !== 1'b1) frame_err++;
        rx_q.push_back(rx_byte);
        rx_on = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int k);
    return (k == 0) ? if1.tx_ready : if2.tx_ready;
  endfunction

  // Present a byte and wait (bounded) for the edge that accepts it; tx_valid
  // is left high for the caller to drop or reuse.
  task automatic send(input int k, input logic [7:0] b, output int acc_edge);
    if (k == 0) begin
      if1.tx_data  = b;
      if1.tx_valid = 1'b1;
    end else begin
      if2.tx_data  = b;
      if2.tx_valid = 1'b1;
    end
    acc_edge = -1;
    for (int i = 0; i < 400 && acc_edge < 0; i++) begin
      if (rdy(k) === 1'b1) begin
        step();
        acc_edge = edge_n;
      end else begin
        step();
      end
    end
    if (acc_edge < 0) chk("send_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         e0, e1, lowc, busyc, errs;
    logic [9:0] pat;
    if1.tx_valid = 1'b0;
    if1.tx_data  = '0;
    if2.tx_valid = 1'b0;
    if2.tx_data  = '0;

    // Reset and 200 idle cycles.
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_tx",    int'(tx1),          1);
    chk("rst_ready", int'(if1.tx_ready), 1);
    chk("rst_busy",  int'(busy1),        0);
    lowc  = 0;
    busyc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      lowc  += int'(tx1 !== 1'b1);
      busyc += int'(busy1 !== 1'b0);
    end
    chk("idle_line", lowc, 0);
    chk("idle_busy", busyc, 0);

    // Single 0x55 frame.
    send(0, 8'h55, e0);
    if1.tx_valid = 1'b0;
    chk("acc_line_high", int'(tx1),          1);
    chk("acc_ready_low", int'(if1.tx_ready), 0);
    step();
    chk("start_fall", int'(tx1), 0);
    pat   = 10'b1010101010;
    errs  = 0;
    busyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx1 !== pat[i/Bps]) errs++;
      busyc += int'(busy1 === 1'b1);
      step();
    end
    chk("f55_bits", errs, 0);
    for (int i = 0; i < 20; i++) begin
      busyc += int'(busy1 === 1'b1);
      step();
    end
    chk("f55_busy_cycles", busyc, 100);
    chk("f55_end_line",    int'(tx1), 1);

    // Back-to-back 0xA3, 0x0F with tx_valid held high.
    rx_q.delete();
    rx_start.delete();
    frame_err = 0;
    send(0, 8'hA3, e0);
    send(0, 8'h0F, e1);
    if1.tx_valid = 1'b0;
    chk("refill_gap", e1 - e0, 2);
    repeat (230) step();
    chk("b2b_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("b2b_byte0", int'(rx_q[0]), 'hA3);
      chk("b2b_byte1", int'(rx_q[1]), 'h0F);
    end
    if (rx_start.size() >= 2) chk("b2b_start_gap", rx_start[1] - rx_start[0], 100);
    chk("b2b_frame_err", frame_err, 0);

    // Two stop bits, 0xFF.
    send(1, 8'hFF, e0);
    if2.tx_valid = 1'b0;
    step();
    chk("sb2_fall", int'(tx2), 0);
    lowc  = 0;
    busyc = 0;
    for (int i = 0; i < 130; i++) begin
      lowc  += int'(tx2 === 1'b0);
      busyc += int'(busy2 === 1'b1);
      step();
    end
    chk("sb2_low_cycles",  lowc,  10);
    chk("sb2_busy_cycles", busyc, 110);

    // Reset at cycle 35 of a 0x00 frame with 0x5A held.
    rx_q.delete();
    rx_start.delete();
    send(0, 8'h00, e0);
    send(0, 8'h5A, e1);
    if1.tx_valid = 1'b0;
    repeat (34) step();
    chk("mid_line_low",   int'(tx1),          0);
    chk("mid_held_ready", int'(if1.tx_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_tx",    int'(tx1),          1);
    chk("abort_ready", int'(if1.tx_ready), 1);
    chk("abort_busy",  int'(busy1),        0);
    lowc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      lowc += int'(tx1 !== 1'b1);
    end
    chk("abort_no_start", lowc, 0);
    chk("abort_no_bytes", rx_q.size(), 0);

    // tx_valid chatter while not ready must not add or alter bytes.
    rx_q.delete();
    rx_start.delete();
    send(0, 8'h3C, e0);
    send(0, 8'hC5, e1);
    for (int i = 0; i < 230; i++) begin
      if (if1.tx_ready === 1'b0) begin
        if1.tx_valid = !if1.tx_valid;
        if1.tx_data  = 8'($urandom);
      end else begin
        if1.tx_valid = 1'b0;
      end
      step();
    end
    if1.tx_valid = 1'b0;
    repeat (20) step();
    chk("chatter_count", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      chk("chatter_byte0", int'(rx_q[0]), 'h3C);
      chk("chatter_byte1", int'(rx_q[1]), 'hC5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
